// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial 8-bit frame receiver with parity/stop checking and a one-deep holding register
module parity_frame_rx #(
    parameter int ODD_PARITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_tick,
    input  logic       rx_in,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic ODD = (ODD_PARITY != 0);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       par_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            par_bit    <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // The acknowledge clear is written first so a completing frame in the same cycle overrides it.
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (bit_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_in) begin
                            state     <= DATA;
                            bit_cnt   <= 3'd0;
                            shift_reg <= 8'h00;
                            busy      <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= rx_in;
                        bit_cnt            <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= rx_in;
                        state   <= STOP;
                    end
                    STOP: begin
                        data_out   <= shift_reg;
                        parity_err <= (^shift_reg) ^ par_bit ^ ODD;
                        frame_err  <= ~rx_in;
                        data_valid <= 1'b1;
                        overrun    <= data_valid && !data_ack;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
